fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Parametrised synchronous FIFO; successor to the fixed 16-bit FIFO used in the streaming/pixel paths.
//  Generalised in data width and depth, with programmable almost-full and almost-empty thresholds.
//  Adds an occupancy count and a selectable first-word-fall-through (FWFT) read mode.
//  Keeps the existing flag set (FULL/EMPTY/OVER/UNDER/VALID) so existing users drop in with defaults.
// PARAMETERS
//  WIDTH      16  data bits per word (>=1)
//  DEPTH      8   entries; power of two, >=4
//  AF_LEVEL   7   almostFULL asserts when COUNT >= AF_LEVEL (1..DEPTH-1)
//  AE_LEVEL   1   almostEMPTY asserts when COUNT <= AE_LEVEL (0..DEPTH-2)
//  FWFT       0   0 = standard read (data 1 cycle after RD); 1 = first-word-fall-through
// PORTS
//  CLK          in   1           clock, rising edge
//  RST          in   1           reset, asynchronous assert, active-low (0 = reset)
//  WR           in   1           write request
//  RD           in   1           read request (standard) / read acknowledge (FWFT)
//  DIN          in   WIDTH       write data
//  DOUT         out  WIDTH       read data
//  COUNT        out  AW+1        stored words, 0..DEPTH (AW = log2 DEPTH)
//  almostFULL   out  1           COUNT >= AF_LEVEL
//  almostEMPTY  out  1           COUNT <= AE_LEVEL
//  FULL         out  1           COUNT == DEPTH
//  EMPTY        out  1           COUNT == 0
//  OVER         out  1           1-cycle pulse: write rejected in previous cycle
//  UNDER        out  1           1-cycle pulse: read rejected in previous cycle
//  VALID        out  1           DOUT holds a valid word this cycle
// BEHAVIOUR
//  Reset (RST=0, async): pointers/COUNT=0; EMPTY=1, almostEMPTY=1, all other flags 0; DOUT=0. Flags are registered.
//  Accept rules per rising edge: wr_ok = WR & (~FULL | rd_ok); rd_ok = RD & ~EMPTY.
//   Full + WR + RD: both accepted, COUNT unchanged, OVER=0. Empty + WR + RD: write accepted; read rejected -> UNDER.
//   WR & FULL & ~RD -> word dropped, OVER=1 next cycle. RD & EMPTY -> UNDER=1 next cycle. No state change on rejection.
//  COUNT: +1 on write only, -1 on read only, unchanged on both or neither; all flags derive from the next COUNT,
//   so they are valid the same cycle COUNT updates. Pointers are AW bits and wrap DEPTH-1 -> 0 silently.
//  Standard mode (FWFT=0): on rd_ok, DOUT loads the head word and VALID=1 in the following cycle only; otherwise VALID=0 and DOUT holds.
//  FWFT mode (FWFT=1): head word is presented on DOUT with VALID=1 whenever the FIFO holds data; RD while VALID pops it.
//   Write to an empty FIFO -> VALID=1 two cycles later (RAM read plus output register). The output register counts in COUNT.
//   RD while VALID=0 is an underflow -> UNDER.
//  Data ordering is strictly first-in first-out; no data written before reset is ever returned after reset.
//  Reset mid-operation: all contents are discarded immediately; the first post-reset write is the first word read.
// STRUCTURE
//  fifo_pkg (shared): clog2 constant function, flag-bit index localparams reused by other stream FIFOs.
//  Sub-module fifo_ram: simple dual-port RAM, WIDTH x DEPTH, synchronous write and synchronous read, no reset on the array.
//  fifo_param holds pointers, COUNT, flag registers, and the FWFT prefetch/output stage (generate on FWFT).
// TESTING (default params, plus WIDTH=32/DEPTH=16/FWFT=1)
//  Write 1..8 -> COUNT=8, FULL=1, almostFULL asserted at COUNT=7; extra WR -> OVER=1 one cycle, COUNT stays 8.
//  Read 8 times (FWFT=0) -> DOUT=1..8, each one cycle after RD with VALID=1; then EMPTY=1, 9th RD -> UNDER=1.
//  Full + WR=RD=1 with DIN=99 -> COUNT=8, OVER=0; after draining, 99 is the last word out.
//  Empty + WR=RD=1 with DIN=5 -> UNDER=1, COUNT=1, next read returns 5.
//  Wrap: 3 rounds of write 6 / read 6 -> data matches a scoreboard across pointer wrap; almostEMPTY tracks COUNT<=1.
//  RST=0 asserted mid-burst between clock edges -> flags reset immediately; after release, write 42 and read -> 42.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFOs: address-width helper and the
// bit positions of the registered status flags.
package fifo_pkg;

   localparam int FLAG_FULL   = 0;
   localparam int FLAG_EMPTY  = 1;
   localparam int FLAG_AFULL  = 2;
   localparam int FLAG_AEMPTY = 3;
   localparam int FLAG_OVER   = 4;
   localparam int FLAG_UNDER  = 5;
   localparam int FLAG_W      = 6;

   // An empty FIFO is also almost-empty for every legal threshold
   localparam logic [FLAG_W-1:0] FLAG_RST = (FLAG_W'(1) << FLAG_EMPTY) | (FLAG_W'(1) << FLAG_AEMPTY);

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a FIFO user (master) and fifo_param (slave).
interface fifo_param_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   import fifo_pkg::*;

   localparam int AW = clog2(DEPTH);

   logic             wr;
   logic             rd;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [AW:0]      count;
   logic             almost_full;
   logic             almost_empty;
   logic             full;
   logic             empty;
   logic             over;
   logic             under;
   logic             valid;

   modport master (
      output wr, rd, din,
      input  dout, count, almost_full, almost_empty, full, empty, over, under, valid
   );

   modport slave (
      input  wr, rd, din,
      output dout, count, almost_full, almost_empty, full, empty, over, under, valid
   );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read
// (read-before-write on an address collision). The array itself is never reset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      re,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered flags, occupancy count and an
// optional first-word-fall-through output stage.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 7,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   fifo_param_if.slave fifo
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_AF  = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0]   CNT_AE  = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count, count_next;
   logic [FLAG_W-1:0] flags_q, flags_next;
   logic              wr_ok, rd_ok, rd_avail, ram_re;
   logic [WIDTH-1:0]  ram_rdata;

   // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it
   always_comb begin
      rd_ok      = fifo.rd & rd_avail;
      wr_ok      = fifo.wr & (~flags_q[FLAG_FULL] | rd_ok);
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
      flags_next              = '0;
      flags_next[FLAG_FULL]   = (count_next == CNT_MAX);
      flags_next[FLAG_EMPTY]  = (count_next == '0);
      flags_next[FLAG_AFULL]  = (count_next >= CNT_AF);
      flags_next[FLAG_AEMPTY] = (count_next <= CNT_AE);
      flags_next[FLAG_OVER]   = fifo.wr & ~wr_ok;
      flags_next[FLAG_UNDER]  = fifo.rd & ~rd_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         flags_q <= FLAG_RST;
      end else begin
         if (wr_ok)  wr_ptr <= wr_ptr + PTR_ONE;
         if (ram_re) rd_ptr <= rd_ptr + PTR_ONE;
         count   <= count_next;
         flags_q <= flags_next;
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (fifo.din),
      .re    (ram_re),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   assign fifo.count        = count;
   assign fifo.full         = flags_q[FLAG_FULL];
   assign fifo.empty        = flags_q[FLAG_EMPTY];
   assign fifo.almost_full  = flags_q[FLAG_AFULL];
   assign fifo.almost_empty = flags_q[FLAG_AEMPTY];
   assign fifo.over         = flags_q[FLAG_OVER];
   assign fifo.under        = flags_q[FLAG_UNDER];

   generate
      if (FWFT == 0) begin : g_std
         logic vld_p1;

         assign rd_avail = ~flags_q[FLAG_EMPTY];
         assign ram_re   = rd_ok;

         // p1: RAM read register is the output; valid for exactly one cycle per read
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_p1 <= 1'b0;
            else        vld_p1 <= rd_ok;
         end

         assign fifo.dout  = ram_rdata;
         assign fifo.valid = vld_p1;
      end else begin : g_fwft
         logic [AW:0]      ram_cnt;
         logic             vld_p1, vld_p2;
         logic             p2_free, p1_adv, issue;
         logic [WIDTH-1:0] dout_p2;

         assign rd_avail = vld_p2;
         assign ram_re   = issue;

         // Prefetch whenever RAM holds unread words and the p1 slot is, or is becoming, free
         always_comb begin
            p2_free = ~vld_p2 | rd_ok;
            p1_adv  = vld_p1 & p2_free;
            issue   = (ram_cnt != '0) & (~vld_p1 | p1_adv);
         end

         // p1: RAM read register; p2: presented output word
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ram_cnt <= '0;
               vld_p1  <= 1'b0;
               vld_p2  <= 1'b0;
               dout_p2 <= '0;
            end else begin
               case ({wr_ok, issue})
                  2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                  2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                  default: ram_cnt <= ram_cnt;
               endcase
               vld_p1 <= issue | (vld_p1 & ~p1_adv);
               if (p2_free) vld_p2  <= vld_p1;
               if (p1_adv)  dout_p2 <= ram_rdata;
            end
         end

         assign fifo.dout  = dout_p2;
         assign fifo.valid = vld_p2;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: default standard-mode instance plus a 32x16 FWFT instance.
module tb_fifo_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_param_if #(.WIDTH(16), .DEPTH(8))  s ();
   fifo_param_if #(.WIDTH(32), .DEPTH(16)) f ();

   fifo_param #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .fifo(s));
   fifo_param #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fw (
      .clk(clk), .rst_n(rst_n), .fifo(f));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [15:0] din;
      int          cnt;
      logic        full;
      logic        empty;
      logic        af;
      logic        ae;
      logic        over;
      logic        under;
      logic        valid;
      logic [15:0] dout;
   } vec_t;

   vec_t        vec [20];
   logic [15:0] sq [$];
   logic [15:0] m_dout;
   logic [31:0] fq [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_std(input string tag, input int cnt, input logic full, input logic empty,
                          input logic af, input logic ae, input logic over, input logic under,
                          input logic valid, input logic [15:0] dout);
      chk({tag, "_cnt"},   64'(s.count),        64'(cnt));
      chk({tag, "_full"},  64'(s.full),         64'(full));
      chk({tag, "_empty"}, 64'(s.empty),        64'(empty));
      chk({tag, "_af"},    64'(s.almost_full),  64'(af));
      chk({tag, "_ae"},    64'(s.almost_empty), 64'(ae));
      chk({tag, "_over"},  64'(s.over),         64'(over));
      chk({tag, "_under"}, 64'(s.under),        64'(under));
      chk({tag, "_valid"}, 64'(s.valid),        64'(valid));
      chk({tag, "_dout"},  64'(s.dout),         64'(dout));
   endtask

   // One cycle on the standard instance against a queue model of the FIFO
   task automatic std_cycle(input string tag, input logic w, input logic r, input logic [15:0] d);
      logic acc_r, acc_w;
      int   n;
      acc_r = r && (sq.size() > 0);
      acc_w = w && ((sq.size() < 8) || acc_r);
      if (acc_r) m_dout = sq.pop_front();
      if (acc_w) sq.push_back(d);
      s.wr = w; s.rd = r; s.din = d;
      tick();
      n = sq.size();
      chk_std(tag, n, n == 8, n == 0, n >= 7, n <= 1, w && !acc_w, r && !acc_r, acc_r, m_dout);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      s.wr = 1'b0; s.rd = 1'b0; s.din = '0;
      f.wr = 1'b0; f.rd = 1'b0; f.din = '0;

      for (int i = 0; i < 8; i++)
         vec[i] = '{wr:1'b1, rd:1'b0, din:16'(i+1), cnt:i+1, full:(i == 7), empty:1'b0,
                    af:(i+1 >= 7), ae:(i+1 <= 1), over:1'b0, under:1'b0, valid:1'b0, dout:16'h0};
      vec[8] = '{wr:1'b1, rd:1'b0, din:16'd77, cnt:8, full:1'b1, empty:1'b0,
                 af:1'b1, ae:1'b0, over:1'b1, under:1'b0, valid:1'b0, dout:16'h0};
      vec[9] = '{wr:1'b0, rd:1'b0, din:16'd0, cnt:8, full:1'b1, empty:1'b0,
                 af:1'b1, ae:1'b0, over:1'b0, under:1'b0, valid:1'b0, dout:16'h0};
      for (int k = 0; k < 8; k++)
         vec[10+k] = '{wr:1'b0, rd:1'b1, din:16'd0, cnt:7-k, full:1'b0, empty:(k == 7),
                       af:(7-k >= 7), ae:(7-k <= 1), over:1'b0, under:1'b0, valid:1'b1, dout:16'(k+1)};
      vec[18] = '{wr:1'b0, rd:1'b1, din:16'd0, cnt:0, full:1'b0, empty:1'b1,
                  af:1'b0, ae:1'b1, over:1'b0, under:1'b1, valid:1'b0, dout:16'd8};
      vec[19] = '{wr:1'b0, rd:1'b0, din:16'd0, cnt:0, full:1'b0, empty:1'b1,
                  af:1'b0, ae:1'b1, over:1'b0, under:1'b0, valid:1'b0, dout:16'd8};

      repeat (2) @(posedge clk);
      #1;
      chk_std("rst", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      chk("fw_rst_cnt",   64'(f.count), 64'(0));
      chk("fw_rst_empty", 64'(f.empty), 64'(1));
      chk("fw_rst_valid", 64'(f.valid), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      tick();

      for (int i = 0; i < 20; i++) begin
         s.wr = vec[i].wr; s.rd = vec[i].rd; s.din = vec[i].din;
         tick();
         chk_std($sformatf("vec%0d", i), vec[i].cnt, vec[i].full, vec[i].empty, vec[i].af,
                 vec[i].ae, vec[i].over, vec[i].under, vec[i].valid, vec[i].dout);
      end
      m_dout = vec[19].dout;

      for (int i = 0; i < 8; i++) std_cycle("fill", 1'b1, 1'b0, 16'(100 + i));
      std_cycle("full_wr_rd", 1'b1, 1'b1, 16'd99);
      for (int i = 0; i < 8; i++) std_cycle("drain", 1'b0, 1'b1, 16'd0);
      chk("last_is_99", 64'(s.dout), 64'(99));

      std_cycle("empty_wr_rd", 1'b1, 1'b1, 16'd5);
      std_cycle("read_5", 1'b0, 1'b1, 16'd0);
      chk("got_5", 64'(s.dout), 64'(5));

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 6; i++) std_cycle("wrap_wr", 1'b1, 1'b0, 16'($urandom));
         for (int i = 0; i < 6; i++) std_cycle("wrap_rd", 1'b0, 1'b1, 16'd0);
      end

      std_cycle("burst", 1'b1, 1'b0, 16'd11);
      std_cycle("burst", 1'b1, 1'b0, 16'd12);
      std_cycle("burst", 1'b1, 1'b0, 16'd13);
      #2;
      s.wr = 1'b0; s.rd = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_std("midrst", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      sq.delete();
      m_dout = 16'h0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      std_cycle("post_wr", 1'b1, 1'b0, 16'd42);
      std_cycle("post_rd", 1'b0, 1'b1, 16'd0);
      chk("post_rst_42", 64'(s.dout), 64'(42));

      f.rd = 1'b1;
      tick();
      chk("fw_under",     64'(f.under), 64'(1));
      chk("fw_under_cnt", 64'(f.count), 64'(0));
      f.rd = 1'b0;
      tick();
      chk("fw_under_clr", 64'(f.under), 64'(0));

      w = 32'hA5A5_0001;
      fq.push_back(w);
      f.wr = 1'b1; f.din = w;
      tick();
      f.wr = 1'b0;
      chk("fw_cnt1",  64'(f.count), 64'(1));
      chk("fw_empty", 64'(f.empty), 64'(0));
      chk("fw_lat0",  64'(f.valid), 64'(0));
      tick();
      chk("fw_lat1",  64'(f.valid), 64'(0));
      tick();
      chk("fw_lat2",  64'(f.valid), 64'(1));
      chk("fw_first", 64'(f.dout),  64'(w));

      for (int i = 1; i < 16; i++) begin
         w = $urandom;
         fq.push_back(w);
         f.wr = 1'b1; f.din = w;
         tick();
         chk($sformatf("fw_fill%0d_cnt", i), 64'(f.count), 64'(i + 1));
         chk($sformatf("fw_fill%0d_af", i),  64'(f.almost_full),  64'(i + 1 >= 14));
         chk($sformatf("fw_fill%0d_ae", i),  64'(f.almost_empty), 64'(i + 1 <= 2));
         chk($sformatf("fw_fill%0d_full", i), 64'(f.full), 64'(i == 15));
      end
      f.din = 32'hDEAD_BEEF;
      tick();
      chk("fw_over",     64'(f.over),  64'(1));
      chk("fw_over_cnt", 64'(f.count), 64'(16));
      f.wr = 1'b0;
      tick();
      chk("fw_over_clr", 64'(f.over),  64'(0));
      chk("fw_head_vld", 64'(f.valid), 64'(1));
      chk("fw_head",     64'(f.dout),  64'(fq[0]));

      f.wr = 1'b1; f.rd = 1'b1; f.din = 32'h0000_0099;
      tick();
      f.wr = 1'b0;
      void'(fq.pop_front());
      fq.push_back(32'h0000_0099);
      chk("fw_fwr_cnt",   64'(f.count), 64'(16));
      chk("fw_fwr_over",  64'(f.over),  64'(0));
      chk("fw_fwr_under", 64'(f.under), 64'(0));

      for (int i = 0; i < 16; i++) begin
         w = fq.pop_front();
         chk($sformatf("fw_drain%0d_vld", i),  64'(f.valid), 64'(1));
         chk($sformatf("fw_drain%0d_data", i), 64'(f.dout),  64'(w));
         tick();
         chk($sformatf("fw_drain%0d_cnt", i),  64'(f.count), 64'(15 - i));
      end
      f.rd = 1'b0;
      chk("fw_end_vld",   64'(f.valid), 64'(0));
      chk("fw_end_empty", 64'(f.empty), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
